// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and helpers
//
// Purpose: receive-FSM state type, idle-detect length in bit times and the
// 3-sample majority vote used by the receiver. Also imported by the TX block.
// Ports: none (package).

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK_WAIT
  } rx_state_t;

  // Line must stay high this many bit times before rx_idle asserts.
  localparam int IDLE_BITS = 10;

  // 2-of-3 majority of three line samples.
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - free-running oversampling tick generator
//
// Purpose: divides clk down to a 1-clk strobe at BAUD_RATE*Oversampling.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous reset, active-high
//   enable  in   count enable; tick is held low while 0
//   tick    out  1-clk strobe at the oversampling rate

module baud_tick_gen #(
  parameter int CLK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int Oversampling  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int DIVISOR = CLK_FREQUENCY / (BAUD_RATE * Oversampling);
  // A divisor of 1 still needs a 1-bit counter to keep the code uniform.
  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 UART receiver with one-entry holding register
//
// Purpose: synchronises rxd, majority-votes three samples at each bit centre,
// assembles LSB-first frames and hands bytes out through a valid/ready
// holding register. Reports framing errors, overruns and an idle line.
// Ports:
//   clk          in   system clock, all logic on posedge
//   rst          in   synchronous reset, active-high
//   rxd          in   asynchronous serial line, idle high
//   rx_data      out  received byte, valid while rx_valid=1
//   rx_valid     out  holding register full
//   rx_ready     in   consumer accept; transfer on rx_valid&&rx_ready
//   framing_err  out  1-clk pulse: stop bit voted 0
//   overrun_err  out  1-clk pulse: byte completed while holding full
//   rx_idle      out  line high for IDLE_BITS bit times since last activity

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int OVERSAMPLING  = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 rx_idle
);

  localparam int OS_W     = $clog2(OVERSAMPLING);
  localparam int BIT_W    = $clog2(DATA_BITS + 1);
  localparam int IDLE_MAX = IDLE_BITS * OVERSAMPLING;
  localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

  localparam logic [OS_W-1:0]   OS_HALF_LAST = OS_W'(OVERSAMPLING / 2 - 1);
  localparam logic [OS_W-1:0]   OS_LAST      = OS_W'(OVERSAMPLING - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST     = BIT_W'(DATA_BITS - 1);
  localparam logic [IDLE_W-1:0] IDLE_TOP     = IDLE_W'(IDLE_MAX);
  localparam logic [IDLE_W-1:0] IDLE_PRE     = IDLE_W'(IDLE_MAX - 1);

  logic tick;

  baud_tick_gen #(
    .CLK_FREQUENCY(CLK_FREQUENCY),
    .BAUD_RATE    (BAUD_RATE),
    .Oversampling (OVERSAMPLING)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .enable(1'b1),
    .tick  (tick)
  );

  // Two-flop synchroniser; resets to the idle (high) line level.
  logic sync_1;
  logic rxd_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b1;
      rxd_s  <= 1'b1;
    end else begin
      sync_1 <= rxd;
      rxd_s  <= sync_1;
    end
  end

  // Two previous tick samples plus the current one form the vote window,
  // so a vote taken on a tick already includes that tick's sample.
  logic [1:0] hist;
  logic       vote;

  assign vote = maj3({hist, rxd_s});

  rx_state_t            state;
  logic [OS_W-1:0]      os_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [IDLE_W-1:0]    idle_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 deliver;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hist        <= 2'b11;
      os_cnt      <= '0;
      bit_cnt     <= '0;
      idle_cnt    <= '0;
      shreg       <= '0;
      deliver     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
      rx_idle     <= 1'b0;
    end else begin
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
      deliver     <= 1'b0;

      if (tick) begin
        hist <= {hist[0], rxd_s};
      end

      // Holding register: a load wins over a plain accept, and an accept in
      // the load clk frees the slot so the new byte is not an overrun.
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      // Idle detect: only high ticks spent in IDLE count; any other state
      // restarts the measurement.
      if (state != IDLE) begin
        idle_cnt <= '0;
        rx_idle  <= 1'b0;
      end else if (tick && rxd_s && (idle_cnt != IDLE_TOP)) begin
        idle_cnt <= idle_cnt + 1'b1;
        if (idle_cnt == IDLE_PRE) begin
          rx_idle <= 1'b1;
        end
      end

      if (tick) begin
        case (state)
          IDLE: begin
            if (!rxd_s) begin
              state  <= START;
              os_cnt <= '0;
            end
          end

          // Half a bit in, confirm the start bit; a high vote means the
          // falling edge was only a glitch.
          START: begin
            if (os_cnt == OS_HALF_LAST) begin
              if (vote) begin
                state <= IDLE;
              end else begin
                state   <= DATA;
                os_cnt  <= '0;
                bit_cnt <= '0;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end

          DATA: begin
            if (os_cnt == OS_LAST) begin
              os_cnt <= '0;
              shreg  <= {vote, shreg[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
                state   <= STOP;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end

          STOP: begin
            if (os_cnt == OS_LAST) begin
              os_cnt <= '0;
              if (vote) begin
                deliver <= 1'b1;
                state   <= IDLE;
              end else begin
                framing_err <= 1'b1;
                state       <= BRK_WAIT;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end

          // A held-low line (break) must not be re-read as new start bits.
          BRK_WAIT: begin
            if (rxd_s) begin
              state <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx

module tb_uart_rx;

  localparam int BIT_CLK = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       framing_err;
  logic       overrun_err;
  logic       rx_idle;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int fe_cnt = 0;
  int oe_cnt = 0;

  uart_rx #(
    .CLK_FREQUENCY(1_600_000),
    .BAUD_RATE    (100_000),
    .OVERSAMPLING (8),
    .DATA_BITS    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .framing_err(framing_err),
    .overrun_err(overrun_err),
    .rx_idle    (rx_idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (framing_err) fe_cnt <= fe_cnt + 1;
    if (overrun_err) oe_cnt <= oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one LSB-first frame, then optionally keeps
  // the line low for extra_low clocks before returning it high.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int extra_low);
    rxd = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BIT_CLK) @(negedge clk);
    if (extra_low > 0) begin
      rxd = 1'b0;
      repeat (extra_low) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  int fe_base;
  int oe_base;
  int t0;

  initial begin
    rst      = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_data",  32'(rx_data), 32'h0);
    check("rst_valid", 32'(rx_valid), 32'h0);
    check("rst_fe",    32'(framing_err), 32'h0);
    check("rst_oe",    32'(overrun_err), 32'h0);
    check("rst_idle",  32'(rx_idle), 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // 1: clean frame 0x55, held until accepted
    fe_base = fe_cnt; oe_base = oe_cnt;
    send_frame(8'h55, 1'b1, 0);
    check("t1_data",  32'(rx_data), 32'h55);
    check("t1_valid", 32'(rx_valid), 32'h1);
    repeat (50) @(negedge clk);
    check("t1_hold_data",  32'(rx_data), 32'h55);
    check("t1_hold_valid", 32'(rx_valid), 32'h1);
    check("t1_no_fe", 32'(fe_cnt - fe_base), 32'h0);
    check("t1_no_oe", 32'(oe_cnt - oe_base), 32'h0);
    pulse_ready();
    check("t1_accepted", 32'(rx_valid), 32'h0);

    // 2: 4-clk glitch rejected by START
    fe_base = fe_cnt;
    repeat (20) @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("t2_idle_cleared", 32'(rx_idle), 32'h0);
    repeat (180) @(negedge clk);
    check("t2_valid", 32'(rx_valid), 32'h0);
    check("t2_no_fe", 32'(fe_cnt - fe_base), 32'h0);

    // 3: bad stop bit followed by a held-low line
    fe_base = fe_cnt; oe_base = oe_cnt;
    send_frame(8'hA3, 1'b0, 40);
    check("t3_fe_once", 32'(fe_cnt - fe_base), 32'h1);
    check("t3_valid",   32'(rx_valid), 32'h0);
    repeat (200) @(negedge clk);
    check("t3_fe_still_once",  32'(fe_cnt - fe_base), 32'h1);
    check("t3_no_spurious",    32'(rx_valid), 32'h0);
    check("t3_no_oe",          32'(oe_cnt - oe_base), 32'h0);

    // 4: back-to-back frames with no consumer -> overrun
    fe_base = fe_cnt; oe_base = oe_cnt;
    send_frame(8'h12, 1'b1, 0);
    send_frame(8'h34, 1'b1, 0);
    check("t4_data_kept", 32'(rx_data), 32'h12);
    check("t4_valid",     32'(rx_valid), 32'h1);
    check("t4_oe_once",   32'(oe_cnt - oe_base), 32'h1);
    check("t4_no_fe",     32'(fe_cnt - fe_base), 32'h0);
    pulse_ready();
    check("t4_accepted", 32'(rx_valid), 32'h0);
    repeat (20) @(negedge clk);

    // 5: accept coincides with the second load -> no overrun, valid stays
    oe_base = oe_cnt;
    t0 = cyc;
    fork
      begin
        send_frame(8'h12, 1'b1, 0);
        send_frame(8'h34, 1'b1, 0);
      end
      begin
        int  lat;
        bit  seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
          @(negedge clk);
          if (rx_valid) seen = 1'b1;
        end
        check("t5_first_load", 32'(seen), 32'h1);
        if (seen) begin
          lat = cyc - t0;
          check("t5_latency_window", 32'(lat >= 150 && lat <= 160), 32'h1);
          // Frames are 160 clk apart, a whole number of ticks, so the
          // second load lands exactly 160 clk after the first.
          while (cyc < t0 + 160 + lat - 1) @(negedge clk);
          check("t5_old_data", 32'(rx_data), 32'h12);
          pulse_ready();
          check("t5_new_data",  32'(rx_data), 32'h34);
          check("t5_valid_kept", 32'(rx_valid), 32'h1);
        end
      end
    join
    repeat (10) @(negedge clk);
    check("t5_no_oe",        32'(oe_cnt - oe_base), 32'h0);
    check("t5_still_valid",  32'(rx_valid), 32'h1);

    // 6: reset mid-DATA, then a clean frame and idle detection
    fork
      send_frame(8'hFF, 1'b1, 0);
      begin
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_data",  32'(rx_data), 32'h0);
        check("t6_rst_valid", 32'(rx_valid), 32'h0);
        check("t6_rst_fe",    32'(framing_err), 32'h0);
        check("t6_rst_oe",    32'(overrun_err), 32'h0);
        check("t6_rst_idle",  32'(rx_idle), 32'h0);
      end
    join
    repeat (20) @(negedge clk);
    check("t6_abandoned", 32'(rx_valid), 32'h0);
    fe_base = fe_cnt; oe_base = oe_cnt;
    send_frame(8'hC3, 1'b1, 0);
    check("t6_data",  32'(rx_data), 32'hC3);
    check("t6_valid", 32'(rx_valid), 32'h1);
    check("t6_no_err", 32'((fe_cnt - fe_base) + (oe_cnt - oe_base)), 32'h0);
    repeat (100) @(negedge clk);
    check("t6_idle_early", 32'(rx_idle), 32'h0);
    repeat (70) @(negedge clk);
    check("t6_idle_set", 32'(rx_idle), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
